// File: rtl/ece571f23_g5_aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES MixColumns engine.
// Bytes are reduced modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
package ece571f23_g5_aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_t;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant multiplier this folds to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = b;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/ece571f23_g5_aes_mixcol_column.sv
// Combinational transform of one 32-bit state column (MixColumns or InvMixColumns).
// Row 0 of the column sits in the most significant byte.
module ece571f23_g5_aes_mixcol_column
  import ece571f23_g5_aes_pkg::*;
(
  input  col_t col,
  input  logic decrypt,
  output col_t mixed
);

  // Every output row uses the same coefficient pattern, rotated by one byte per row.
  function automatic logic [7:0] mix_row(input logic [7:0] x0, input logic [7:0] x1,
                                         input logic [7:0] x2, input logic [7:0] x3,
                                         input logic dec);
    if (dec)
      return gf_mul(x0, 8'h0e) ^ gf_mul(x1, 8'h0b) ^ gf_mul(x2, 8'h0d) ^ gf_mul(x3, 8'h09);
    return gf_xtime(x0) ^ gf_xtime(x1) ^ x1 ^ x2 ^ x3;
  endfunction

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign mixed = {mix_row(a0, a1, a2, a3, decrypt),
                  mix_row(a1, a2, a3, a0, decrypt),
                  mix_row(a2, a3, a0, a1, decrypt),
                  mix_row(a3, a0, a1, a2, decrypt)};

endmodule

// File: rtl/ece571f23_g5_aes_mixcol_engine.sv
// Folded AES MixColumns/InvMixColumns engine with final-round bypass and valid/ready
// handshakes; COLS_PER_CYCLE columns of the working state are rewritten per BUSY cycle.
module ece571f23_g5_aes_mixcol_engine
  import ece571f23_g5_aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int NUM_COLS       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int IDX_W = $clog2(NUM_COLS) + 1;
  localparam int SEL_W = $clog2(NUM_COLS);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  if (NUM_COLS != NB) begin : g_bad_nb
    $error("NUM_COLS must be 4");
  end

  mc_state_t        state;
  mc_state_t        next_state;
  logic [IDX_W-1:0] col_idx;
  state_t           work;
  state_t           work_next;
  logic             decrypt_q;
  logic             bypass_q;
  logic             load;
  logic             last_group;

  col_t grp_col   [COLS_PER_CYCLE];
  col_t grp_mixed [COLS_PER_CYCLE];

  assign last_group = (col_idx == IDX_W'(NUM_COLS - COLS_PER_CYCLE));

  // col_idx only reaches NUM_COLS in DONE, where its low bits select column 0 harmlessly.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign grp_col[g] = work[32*(int'(col_idx[SEL_W-1:0]) + g) +: 32];

    ece571f23_g5_aes_mixcol_column u_column (
      .col     (grp_col[g]),
      .decrypt (decrypt_q),
      .mixed   (grp_mixed[g])
    );
  end

  always_comb begin
    work_next = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_next[32*(int'(col_idx[SEL_W-1:0]) + g) +: 32] = bypass_q ? grp_col[g] : grp_mixed[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // in_ready depends only on state and out_ready, so upstream never sees a loop through in_valid.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (last_group) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load       = 1'b1;
            next_state = BUSY;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Mode and bypass are captured only at accept so mid-block input changes have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx   <= '0;
      work      <= '0;
      decrypt_q <= 1'b0;
      bypass_q  <= 1'b0;
    end else if (load) begin
      col_idx   <= '0;
      work      <= in_data;
      decrypt_q <= in_decrypt;
      bypass_q  <= in_bypass;
    end else if (state == BUSY) begin
      col_idx   <= col_idx + IDX_W'(COLS_PER_CYCLE);
      work      <= work_next;
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_ece571f23_g5_aes_mixcol_engine.sv
// Scoreboard bench for the MixColumns engine: one instance per legal COLS_PER_CYCLE.
// Expected blocks are queued on accept and compared when the engine hands them off.
module tb_ece571f23_g5_aes_mixcol_engine;

  logic         clk;
  logic         rst_n;
  logic         in_valid   [3];
  logic         in_ready   [3];
  logic [127:0] in_data    [3];
  logic         in_decrypt [3];
  logic         in_bypass  [3];
  logic         out_valid  [3];
  logic         out_ready  [3];
  logic [127:0] out_data   [3];
  logic         busy       [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q [$];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int C = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    ece571f23_g5_aes_mixcol_engine #(.COLS_PER_CYCLE(C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[k]),
      .in_ready   (in_ready[k]),
      .in_data    (in_data[k]),
      .in_decrypt (in_decrypt[k]),
      .in_bypass  (in_bypass[k]),
      .out_valid  (out_valid[k]),
      .out_ready  (out_ready[k]),
      .out_data   (out_data[k]),
      .busy       (busy[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int colsOf(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Reference arithmetic written as explicit xtime chains.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] refCol(input logic [31:0] c, input logic dec);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (dec)
        r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                       ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                       ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                       ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      else
        r[31-8*i -: 8] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

  function automatic logic [127:0] refModel(input logic [127:0] d, input logic dec, input logic byp);
    logic [127:0] r;
    if (byp) return d;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = refCol(d[32*i +: 32], dec);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [127:0] d,
                               input logic dec, input logic byp, input logic rdy);
    in_valid[k]   = v;
    in_data[k]    = d;
    in_decrypt[k] = dec;
    in_bypass[k]  = byp;
    out_ready[k]  = rdy;
  endtask

  // One clock cycle on instance k: drive, then judge which handshakes fire at the next edge.
  task automatic runCycle(input int k, input logic v, input logic [127:0] d, input logic dec,
                          input logic byp, input logic rdy,
                          output logic acc, output logic em, output logic ov);
    @(posedge clk);
    #1;
    applyStimulus(k, v, d, dec, byp, rdy);
    #1;
    ov  = out_valid[k];
    acc = v && in_ready[k];
    em  = out_valid[k] && rdy;
    if (em) begin
      if (exp_q.size() == 0) checkOutput("unexpected_out", out_data[k], '0);
      else                   checkOutput("scoreboard", out_data[k], exp_q.pop_front());
    end
    if (acc) exp_q.push_back(refModel(d, dec, byp));
  endtask

  task automatic sendBlock(input int k, input logic [127:0] d, input logic dec, input logic byp,
                           input logic rdy, output logic [127:0] res, output int lat);
    logic acc, em, ov;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      runCycle(k, 1'b1, d, dec, byp, 1'b1, acc, em, ov);
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 0, 1);
    lat = 0;
    ov = 1'b0;
    while (!ov && lat < 50) begin
      runCycle(k, 1'b0, '0, 1'b0, 1'b0, rdy, acc, em, ov);
      lat++;
    end
    if (!ov) checkOutput("output_timeout", 0, 1);
    res = out_data[k];
  endtask

  logic [127:0] res, res2, x, blk_a, blk_b, rd;
  logic acc, em, ov, have, rdec, rbyp, rrdy;
  int lat, sent, cycles;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #23;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_out_valid", out_valid[k], 0);
      checkOutput("rst_in_ready", in_ready[k], 1);
      checkOutput("rst_busy", busy[k], 0);
      checkOutput("rst_out_data", out_data[k], '0);
    end
    #4 rst_n = 1'b1;

    sendBlock(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("enc_c1_data", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    checkOutput("enc_c1_latency", lat, 5);

    sendBlock(2, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, 1'b0, 1'b1, res, lat);
    checkOutput("dec_c4_data", res, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
    checkOutput("dec_c4_latency", lat, 2);

    sendBlock(1, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1, 1'b1, res, lat);
    checkOutput("bypass_c2_data", res, 128'h00112233_44556677_8899aabb_ccddeeff);
    checkOutput("bypass_c2_latency", lat, 3);

    blk_a = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    blk_b = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    sendBlock(0, blk_a, 1'b0, 1'b0, 1'b0, res, lat);
    for (int i = 0; i < 5; i++) begin
      runCycle(0, 1'b1, blk_b, 1'b1, 1'b0, 1'b0, acc, em, ov);
      checkOutput("bp_valid", ov, 1);
      checkOutput("bp_stable", out_data[0], 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      checkOutput("bp_in_ready", in_ready[0], 0);
    end
    runCycle(0, 1'b1, blk_b, 1'b1, 1'b0, 1'b1, acc, em, ov);
    checkOutput("bp_release_accept", acc, 1);
    checkOutput("bp_release_drain", em, 1);
    ov = 1'b0;
    lat = 0;
    while (!ov && lat < 50) begin
      runCycle(0, 1'b0, '0, 1'b0, 1'b0, 1'b1, acc, em, ov);
      lat++;
    end
    checkOutput("bp_second_latency", lat, 5);
    checkOutput("bp_second_data", out_data[0], 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);

    runCycle(1, 1'b1, 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 1'b0, 1'b0, 1'b1, acc, em, ov);
    checkOutput("rst_mid_accept", acc, 1);
    runCycle(1, 1'b0, '0, 1'b0, 1'b0, 1'b1, acc, em, ov);
    checkOutput("rst_mid_busy", busy[1], 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", out_valid[1], 0);
    checkOutput("rst_mid_in_ready", in_ready[1], 1);
    checkOutput("rst_mid_busy_low", busy[1], 0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      runCycle(1, 1'b0, '0, 1'b0, 1'b0, 1'b1, acc, em, ov);
      checkOutput("rst_no_stale", ov, 0);
    end
    sendBlock(1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("post_rst_data", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      sendBlock(2, x, 1'b0, 1'b0, 1'b1, res, lat);
      sendBlock(2, res, 1'b1, 1'b0, 1'b1, res2, lat);
      checkOutput("roundtrip", res2, x);
    end

    for (int k = 0; k < 3; k++) begin
      sent = 0;
      cycles = 0;
      have = 1'b0;
      rd = '0;
      rdec = 1'b0;
      rbyp = 1'b0;
      while ((sent < 334 || have || exp_q.size() != 0) && cycles < 20000) begin
        if (!have) begin
          rd   = {$urandom, $urandom, $urandom, $urandom};
          rdec = 1'($urandom_range(0, 1));
          rbyp = ($urandom_range(0, 7) == 0);
          if (sent < 334 && $urandom_range(0, 9) < 7) have = 1'b1;
        end
        rrdy = ($urandom_range(0, 9) < 7);
        runCycle(k, have, rd, rdec, rbyp, rrdy, acc, em, ov);
        if (acc) begin
          have = 1'b0;
          sent++;
        end
        cycles++;
      end
      if (cycles >= 20000) checkOutput("random_timeout", cycles, 0);
      $display("[TB] random phase COLS_PER_CYCLE=%0d: %0d blocks in %0d cycles", colsOf(k), sent, cycles);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
